// File: rtl/quant_pkg.sv
// Shared types and helpers for the quantizer output packer.
// QUANT_PACK_TRANSPOSE_EN selects column-major emission order in elem_flat.
package quant_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } pack_state_e;

    function automatic int calc_beats(input int total, input int lanes);
        return (total + lanes - 1) / lanes;
    endfunction

    // Emission index -> flat storage index (row * cols + col).
    function automatic int elem_flat(input int e, input int rows, input int cols);
`ifdef QUANT_PACK_TRANSPOSE_EN
        return (e % rows) * cols + (e / rows);
`else
        return (e / cols) * cols + (e % cols);
`endif
    endfunction

endpackage

// File: rtl/quant_tile_buffer.sv
// Two-slot tile store: full-tile write port, beat-wide read port.
// A write to the slot being read is forwarded so a tile can stream on the next cycle.
module quant_tile_buffer
    import quant_pkg::*;
#(
    parameter int ROWS      = 32,
    parameter int COLS      = 16,
    parameter int OUT_WIDTH = 8,
    parameter int LANES     = 16,
    parameter int BW        = 5
)(
    input  logic                            clk,
    input  logic                            wr_en_i,
    input  logic                            wr_slot_i,
    input  logic [ROWS*COLS*OUT_WIDTH-1:0]  wr_tile_i,
    input  logic                            rd_slot_i,
    input  logic [BW-1:0]                   rd_beat_i,
    output logic [LANES*OUT_WIDTH-1:0]      rd_data_o,
    output logic [LANES-1:0]                rd_keep_o
);

    localparam int TOTAL = ROWS * COLS;
    localparam int TW    = TOTAL * OUT_WIDTH;
    localparam int IW    = $clog2(TW);

    logic [TW-1:0] slot_q [2];
    logic [TW-1:0] src_s;
    logic [IW-1:0] bit_idx_s [LANES];

    // Tile capture into the selected slot.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            slot_q[wr_slot_i] <= wr_tile_i;
        end
    end

    // Beat gather; lanes past the end of the tile read as zero with keep low.
    always_comb begin
        rd_data_o = '0;
        rd_keep_o = '0;
        if (wr_en_i && (wr_slot_i == rd_slot_i)) begin
            src_s = wr_tile_i;
        end else begin
            src_s = slot_q[rd_slot_i];
        end
        for (int l = 0; l < LANES; l++) begin
            if ((int'(rd_beat_i) * LANES + l) < TOTAL) begin
                bit_idx_s[l] = IW'(elem_flat(int'(rd_beat_i) * LANES + l, ROWS, COLS) * OUT_WIDTH);
                rd_data_o[l*OUT_WIDTH +: OUT_WIDTH] = src_s[bit_idx_s[l] +: OUT_WIDTH];
                rd_keep_o[l] = 1'b1;
            end else begin
                bit_idx_s[l] = '0;
                rd_data_o[l*OUT_WIDTH +: OUT_WIDTH] = '0;
                rd_keep_o[l] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/quant_out_packer.sv
// Ping-pong drain from the quantizer to an AXI-Stream-style master port.
// Define QUANT_PACK_TRANSPOSE_EN for column-major emission order.
module quant_out_packer
    import quant_pkg::*;
#(
    parameter int ROWS      = 32,
    parameter int COLS      = 16,
    parameter int OUT_WIDTH = 8,
    parameter int LANES     = 16
)(
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           in_valid,
    input  logic signed [ROWS-1:0][COLS-1:0][OUT_WIDTH-1:0] data_in,
    output logic                                           in_ready,
    output logic [LANES*OUT_WIDTH-1:0]                     m_tdata,
    output logic [LANES-1:0]                               m_tkeep,
    output logic                                           m_tlast,
    output logic                                           m_tvalid,
    input  logic                                           m_tready,
    output logic                                           overflow,
    output logic [15:0]                                    tile_count
);

    localparam int TOTAL = ROWS * COLS;
    localparam int BEATS = calc_beats(TOTAL, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    pack_state_e                 state_q;
    logic [BW-1:0]               beat_q;
    logic [1:0]                  cnt_q;
    logic [1:0]                  cnt_d;
    logic                        wr_ptr_q;
    logic                        rd_ptr_q;
    logic                        in_ready_q;
    logic                        overflow_q;
    logic [15:0]                 tile_count_q;
    logic [LANES*OUT_WIDTH-1:0]  tdata_q;
    logic [LANES-1:0]            tkeep_q;
    logic                        tlast_q;
    logic                        tvalid_q;

    logic                        cap_s;
    logic                        drop_s;
    logic                        hs_s;
    logic                        last_s;
    logic                        rd_slot_s;
    logic [BW-1:0]               rd_beat_s;
    logic                        rd_last_s;
    logic [LANES*OUT_WIDTH-1:0]  buf_data_s;
    logic [LANES-1:0]            buf_keep_s;

    quant_tile_buffer #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .OUT_WIDTH (OUT_WIDTH),
        .LANES     (LANES),
        .BW        (BW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (cap_s),
        .wr_slot_i (wr_ptr_q),
        .wr_tile_i (data_in),
        .rd_slot_i (rd_slot_s),
        .rd_beat_i (rd_beat_s),
        .rd_data_o (buf_data_s),
        .rd_keep_o (buf_keep_s)
    );

    // Occupancy bookkeeping and selection of the beat to load next.
    always_comb begin
        cap_s     = in_valid && (cnt_q != 2'd2);
        drop_s    = in_valid && (cnt_q == 2'd2);
        hs_s      = (state_q == ST_STREAM) && tvalid_q && m_tready;
        last_s    = hs_s && (beat_q == LAST_BEAT);
        cnt_d     = cnt_q + {1'b0, cap_s} - {1'b0, last_s};
        rd_slot_s = rd_ptr_q;
        rd_beat_s = '0;
        if (last_s) begin
            rd_slot_s = ~rd_ptr_q;
        end else if (hs_s) begin
            rd_beat_s = beat_q + BW'(1);
        end else begin
            rd_beat_s = '0;
        end
        rd_last_s = (rd_beat_s == LAST_BEAT);
    end

    // Packer FSM with pointers, counters and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            cnt_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            overflow_q   <= 1'b0;
            tile_count_q <= 16'd0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != 2'd2);
            if (cap_s) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q != 2'd0) begin
                        state_q  <= ST_STREAM;
                        beat_q   <= '0;
                        tdata_q  <= buf_data_s;
                        tkeep_q  <= buf_keep_s;
                        tlast_q  <= rd_last_s;
                        tvalid_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (last_s) begin
                        rd_ptr_q     <= ~rd_ptr_q;
                        tile_count_q <= tile_count_q + 16'd1;
                        if (cnt_d != 2'd0) begin
                            beat_q  <= '0;
                            tdata_q <= buf_data_s;
                            tkeep_q <= buf_keep_s;
                            tlast_q <= rd_last_s;
                        end else begin
                            state_q  <= ST_IDLE;
                            beat_q   <= '0;
                            tdata_q  <= '0;
                            tkeep_q  <= '0;
                            tlast_q  <= 1'b0;
                            tvalid_q <= 1'b0;
                        end
                    end else if (hs_s) begin
                        beat_q  <= rd_beat_s;
                        tdata_q <= buf_data_s;
                        tkeep_q <= buf_keep_s;
                        tlast_q <= rd_last_s;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign overflow   = overflow_q;
    assign tile_count = tile_count_q;
    assign m_tdata    = tdata_q;
    assign m_tkeep    = tkeep_q;
    assign m_tlast    = tlast_q;
    assign m_tvalid   = tvalid_q;

endmodule

// File: tb/tb_quant_out_packer.sv
// Self-checking bench for quant_out_packer: default 16-lane instance plus a 24-lane
// instance for the partial final beat, checked against a tile-queue reference model.
module tb_quant_out_packer;

    localparam int ROWS    = 32;
    localparam int COLS    = 16;
    localparam int W       = 8;
    localparam int LANES   = 16;
    localparam int TOTAL   = ROWS * COLS;
    localparam int BEATS   = 32;
    localparam int L24     = 24;
    localparam int BEATS24 = 22;

    typedef logic [ROWS-1:0][COLS-1:0][W-1:0] tile_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_valid24 = 1'b0;
    tile_t              data_in = '0;
    logic               m_tready = 1'b1;
    logic               m_tready24 = 1'b1;

    logic               in_ready, in_ready24;
    logic [127:0]       m_tdata;
    logic [191:0]       m_tdata24;
    logic [15:0]        m_tkeep;
    logic [23:0]        m_tkeep24;
    logic               m_tlast, m_tlast24, m_tvalid, m_tvalid24;
    logic               overflow, overflow24;
    logic [15:0]        tile_count, tile_count24;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_tc  = 0;
    tile_t exp_q[$];

    always #5 clk = ~clk;

    quant_out_packer #(.ROWS(ROWS), .COLS(COLS), .OUT_WIDTH(W), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .in_ready(in_ready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .overflow(overflow), .tile_count(tile_count)
    );

    quant_out_packer #(.ROWS(ROWS), .COLS(COLS), .OUT_WIDTH(W), .LANES(L24)) dut24 (
        .clk(clk), .reset(reset), .in_valid(in_valid24), .data_in(data_in),
        .in_ready(in_ready24), .m_tdata(m_tdata24), .m_tkeep(m_tkeep24), .m_tlast(m_tlast24),
        .m_tvalid(m_tvalid24), .m_tready(m_tready24), .overflow(overflow24), .tile_count(tile_count24)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] elem(input tile_t t, input int e);
`ifdef QUANT_PACK_TRANSPOSE_EN
        return t[e % ROWS][e / ROWS];
`else
        return t[e / COLS][e % COLS];
`endif
    endfunction

    function automatic logic [191:0] exp_data(input tile_t t, input int b, input int lanes);
        logic [191:0] r = '0;
        for (int l = 0; l < lanes; l++) begin
            if (b * lanes + l < TOTAL) r[l*W +: W] = elem(t, b * lanes + l);
        end
        return r;
    endfunction

    function automatic logic [23:0] exp_keep(input int b, input int lanes);
        logic [23:0] k = '0;
        for (int l = 0; l < lanes; l++) begin
            if (b * lanes + l < TOTAL) k[l] = 1'b1;
        end
        return k;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                t[r][c] = 8'($urandom);
        return t;
    endfunction

    // Drive m_tready (mode 0: always 1, mode 1: 0,1,0,1 from first valid), check every
    // presented beat, optionally capture inj_tile on the accept of beat inj_beat.
    task automatic run_stream(input int mode, input int inj_beat, input tile_t inj_tile,
                              output int n_beats, output int first_cyc, output int span,
                              output logic [127:0] first_data);
        int b = 0;
        int last_acc = -1;
        logic prev_stall = 1'b0;
        logic injected = 1'b0;
        logic [127:0] prev_data = '0;
        n_beats = 0; first_cyc = -1; span = 0; first_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (exp_q.size() == 0 && !m_tvalid) break;
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {191'd0, m_tvalid}, 192'd0);
                    break;
                end
                if (first_cyc < 0) begin
                    first_cyc  = cyc;
                    first_data = m_tdata;
                end
                if (prev_stall) check("stall_hold", {64'd0, m_tdata}, {64'd0, prev_data});
                check("beat_data", {64'd0, m_tdata}, exp_data(exp_q[0], b, LANES));
                check("beat_keep", {176'd0, m_tkeep}, {168'd0, exp_keep(b, LANES)});
                check("beat_last", {191'd0, m_tlast}, {191'd0, (b == BEATS - 1)});
                m_tready = (mode == 0) ? 1'b1 : (((cyc - first_cyc) % 2) == 1);
                if (inj_beat >= 0 && !injected && b == inj_beat && m_tready) begin
                    in_valid = 1'b1;
                    data_in  = inj_tile;
                    exp_q.push_back(inj_tile);
                    injected = 1'b1;
                end
                prev_stall = !m_tready;
                prev_data  = m_tdata;
                if (m_tready) begin
                    n_beats++;
                    last_acc = cyc;
                    if (b == BEATS - 1) begin
                        b = 0;
                        void'(exp_q.pop_front());
                        exp_tc++;
                    end else begin
                        b++;
                    end
                end
            end
        end
        in_valid = 1'b0;
        check("stream_drained", exp_q.size(), 192'd0);
        span = (first_cyc < 0) ? 0 : last_acc - first_cyc + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tile_t ta, tb2, tc1, tc2, tc3, td, te, tf, tg;
        int nb, fc, sp, b24;
        logic [127:0] fd;
        logic [127:0] beat0_const;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_tvalid", {191'd0, m_tvalid}, 192'd0);
        check("rst_tlast", {191'd0, m_tlast}, 192'd0);
        check("rst_tdata", {64'd0, m_tdata}, 192'd0);
        check("rst_tkeep", {176'd0, m_tkeep}, 192'd0);
        check("rst_overflow", {191'd0, overflow}, 192'd0);
        check("rst_tile_count", {176'd0, tile_count}, 192'd0);
        check("rst_in_ready", {191'd0, in_ready}, 192'd1);
        check("rst_tvalid24", {191'd0, m_tvalid24}, 192'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single ramp tile.
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                ta[i][j] = 8'((i * 16 + j) % 256);
        data_in = ta; in_valid = 1'b1; exp_q.push_back(ta);
        run_stream(0, -1, ta, nb, fc, sp, fd);
`ifdef QUANT_PACK_TRANSPOSE_EN
        beat0_const = 128'hf0e0d0c0b0a090807060504030201000;
`else
        beat0_const = 128'h0f0e0d0c0b0a09080706050403020100;
`endif
        check("single_latency", fc, 192'd1);
        check("single_beats", nb, BEATS);
        check("single_span", sp, BEATS);
        check("single_beat0", {64'd0, fd}, {64'd0, beat0_const});
        check("single_tile_count", {176'd0, tile_count}, exp_tc);

        // Back-pressure with alternating ready.
        tb2 = rand_tile();
        @(negedge clk);
        data_in = tb2; in_valid = 1'b1; exp_q.push_back(tb2);
        run_stream(1, -1, tb2, nb, fc, sp, fd);
        check("bp_beats", nb, BEATS);
        check("bp_span", sp, 2 * BEATS);
        check("bp_tile_count", {176'd0, tile_count}, exp_tc);

        // Overflow: three pulses with downstream stalled.
        m_tready = 1'b0;
        tc1 = rand_tile(); tc2 = rand_tile(); tc3 = rand_tile();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = (k == 0) ? tc1 : ((k == 1) ? tc2 : tc3);
            if (k < 2) exp_q.push_back(data_in);
            @(negedge clk);
            in_valid = 1'b0;
            if (k == 1) check("ovf_not_yet", {191'd0, overflow}, 192'd0);
            repeat (2) @(negedge clk);
        end
        check("ovf_flag", {191'd0, overflow}, 192'd1);
        check("ovf_in_ready", {191'd0, in_ready}, 192'd0);
        check("ovf_tvalid_held", {191'd0, m_tvalid}, 192'd1);
        check("ovf_tile_count_hold", {176'd0, tile_count}, exp_tc);
        run_stream(0, -1, tc1, nb, fc, sp, fd);
        check("ovf_beats", nb, 2 * BEATS);
        check("ovf_tile_count", {176'd0, tile_count}, exp_tc);
        check("ovf_sticky", {191'd0, overflow}, 192'd1);
        check("ovf_in_ready_back", {191'd0, in_ready}, 192'd1);

        // Capture coinciding with the last beat: next tile follows with no bubble.
        td = rand_tile(); te = rand_tile();
        @(negedge clk);
        data_in = td; in_valid = 1'b1; exp_q.push_back(td);
        run_stream(0, BEATS - 1, te, nb, fc, sp, fd);
        check("b2b_beats", nb, 2 * BEATS);
        check("b2b_span", sp, 2 * BEATS);
        check("b2b_tile_count", {176'd0, tile_count}, exp_tc);

        // Reset at beat 10 of an in-flight tile.
        tf = rand_tile();
        @(negedge clk);
        data_in = tf; in_valid = 1'b1; m_tready = 1'b1;
        b24 = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (m_tvalid) begin
                if (b24 == 10) begin
                    check("mid_beat10", {64'd0, m_tdata}, exp_data(tf, 10, LANES));
                    reset = 1'b0;
                    break;
                end
                b24++;
            end
        end
        @(negedge clk);
        reset = 1'b1;
        exp_tc = 0;
        exp_q.delete();
        check("mid_rst_tvalid", {191'd0, m_tvalid}, 192'd0);
        check("mid_rst_tlast", {191'd0, m_tlast}, 192'd0);
        check("mid_rst_tile_count", {176'd0, tile_count}, 192'd0);
        check("mid_rst_in_ready", {191'd0, in_ready}, 192'd1);
        check("mid_rst_overflow", {191'd0, overflow}, 192'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_idle", {191'd0, m_tvalid}, 192'd0);
        data_in = te; in_valid = 1'b1; exp_q.push_back(te);
        run_stream(0, -1, te, nb, fc, sp, fd);
        check("post_rst_latency", fc, 192'd1);
        check("post_rst_beats", nb, BEATS);
        check("post_rst_tile_count", {176'd0, tile_count}, 192'd1);

        // Partial final beat on the 24-lane instance.
        tg = rand_tile();
        @(negedge clk);
        data_in = tg; in_valid24 = 1'b1;
        b24 = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            in_valid24 = 1'b0;
            if (m_tvalid24) begin
                check("p24_data", m_tdata24, exp_data(tg, b24, L24));
                check("p24_keep", {168'd0, m_tkeep24}, {168'd0, exp_keep(b24, L24)});
                check("p24_last", {191'd0, m_tlast24}, {191'd0, (b24 == BEATS24 - 1)});
                if (b24 == BEATS24 - 1) begin
                    check("p24_keep_tail", {168'd0, m_tkeep24}, {168'd0, 24'h0000FF});
                    check("p24_upper_zero", {128'd0, m_tdata24[191:64]}, 192'd0);
                end
                b24++;
            end else if (b24 > 0) begin
                break;
            end
        end
        check("p24_beats", b24, BEATS24);
        check("p24_tile_count", {176'd0, tile_count24}, 192'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
